// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD minutes:seconds timer.
package bcd_timer_pkg;

    typedef logic [3:0] bcd_nibble_t;

    typedef enum logic [1:0] {
        X1 = 2'd0,
        X2 = 2'd1,
        X4 = 2'd2,
        X8 = 2'd3
    } speed_t;

    // True when every nibble is a decimal digit and the seconds-tens field is 0..5.
    function automatic logic bcd_valid(input logic [19:0] v, input int unsigned nibbles);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < nibbles; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        if (v[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Control and display signals of the BCD timer.
interface bcd_timer_if #(
    parameter int QW = 16
) ();
    logic          START;
    logic          REVERSE;
    logic          SPEED_UP;
    logic          SPEED_DOWN;
    logic          ADD;
    logic          SUBTRACT;
    logic          LOAD;
    logic [QW-1:0] PRESET;
    logic          HOLD;
    logic [QW-1:0] Q;
    logic          RUNNING;
    logic          DONE;
    logic          LOAD_ERR;

    modport master (
        output START, REVERSE, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LOAD, PRESET, HOLD,
        input  Q, RUNNING, DONE, LOAD_ERR
    );

    modport slave (
        input  START, REVERSE, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LOAD, PRESET, HOLD,
        output Q, RUNNING, DONE, LOAD_ERR
    );
endinterface

// File: rtl/bcd_timer_digit_cnt.sv
// One up/down BCD digit; load has priority over counting, carry/borrow is combinational.
module bcd_digit_cnt
    import bcd_timer_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic        i_clk,
    input  logic        i_ld,
    input  bcd_nibble_t i_ld_val,
    input  logic        i_en,
    input  logic        i_up,
    output bcd_nibble_t o_q,
    output bcd_nibble_t o_nxt,
    output logic        o_co
);
    localparam bcd_nibble_t TOP = 4'(MODULUS - 1);

    always_comb begin
        o_co  = i_en && (i_up ? (o_q == TOP) : (o_q == 4'd0));
        o_nxt = o_q;
        if (i_ld) begin
            o_nxt = i_ld_val;
        end else if (i_en) begin
            if (i_up) o_nxt = (o_q == TOP) ? 4'd0 : o_q + 4'd1;
            else      o_nxt = (o_q == 4'd0) ? TOP : o_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        o_q <= o_nxt;
    end
endmodule

// File: rtl/bcd_timer.sv
// BCD MM:SS up/down timer with speed prescaler, limit stop, minute adjust, preset load and lap hold.
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int                      MIN_DIGITS = 2,
    parameter int                      TICK_DIV   = 100,
    parameter logic [8+4*MIN_DIGITS-1:0] LIM_LO   = 16'h1020,
    parameter logic [8+4*MIN_DIGITS-1:0] LIM_HI   = 16'h4930
) (
    input logic        clk_in,
    input logic        RESET,
    bcd_timer_if.slave bus
);
    localparam int          QW = 8 + 4*MIN_DIGITS;
    localparam int unsigned ND = 2 + MIN_DIGITS;
    localparam int          PW = $clog2(TICK_DIV + 8);

    logic [QW-1:0] w_cnt, w_cnt_nxt, w_ld_val, w_lim_act, w_rst_val, w_adj_val, r_held;
    logic [QW:0]   w_mstep;
    logic [ND-1:0] w_en, w_co;
    logic [PW-1:0] r_pre, w_step, w_pre_sum;
    speed_t        r_speed;
    logic          w_running, w_tick, w_adv, w_load_ok, w_ld, w_addsub, w_hold_rise, r_hold_d;
    logic          w_unused_co;

    // +/- one minute on the minute digits only; MSB of the result flags overflow/underflow.
    function automatic logic [QW:0] min_step(input logic [QW-1:0] v, input logic up);
        logic [QW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (r[8+4*i +: 4] == 4'd9) r[8+4*i +: 4] = 4'd0;
                    else begin r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd1; c = 1'b0; end
                end else begin
                    if (r[8+4*i +: 4] == 4'd0) r[8+4*i +: 4] = 4'd9;
                    else begin r[8+4*i +: 4] = r[8+4*i +: 4] - 4'd1; c = 1'b0; end
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        w_lim_act = bus.REVERSE ? LIM_LO : LIM_HI;
        w_rst_val = bus.REVERSE ? LIM_HI : LIM_LO;
        w_running = bus.START && (w_cnt != w_lim_act);
        w_step    = PW'(1) << r_speed;
        w_pre_sum = r_pre + w_step;
        w_tick    = w_running && (w_pre_sum >= PW'(TICK_DIV));
        w_load_ok = bcd_valid(20'(bus.PRESET), ND) && (bus.PRESET >= LIM_LO) && (bus.PRESET <= LIM_HI);
        w_addsub  = bus.ADD || bus.SUBTRACT;
        w_adv     = w_tick && !RESET && !bus.LOAD && !w_addsub;
        w_ld      = RESET || (bus.LOAD && w_load_ok) || (!bus.LOAD && w_addsub);
        w_mstep   = '0;
        w_adj_val = w_cnt;
        if (bus.ADD && !bus.SUBTRACT) begin
            w_mstep   = min_step(w_cnt, 1'b1);
            w_adj_val = (w_mstep[QW] || (w_mstep[QW-1:0] > LIM_HI)) ? LIM_HI : w_mstep[QW-1:0];
        end else if (bus.SUBTRACT && !bus.ADD) begin
            w_mstep   = min_step(w_cnt, 1'b0);
            w_adj_val = (w_mstep[QW] || (w_mstep[QW-1:0] < LIM_LO)) ? LIM_LO : w_mstep[QW-1:0];
        end
        w_ld_val    = RESET ? w_rst_val : (bus.LOAD ? bus.PRESET : w_adj_val);
        w_hold_rise = bus.HOLD && !r_hold_d;
    end

    // Digit 0 is seconds ones, digit 1 seconds tens (mod 6), the rest minutes.
    assign w_en[0] = w_adv;
    for (genvar g = 0; g < ND; g++) begin : g_dig
        if (g > 0) begin : g_chain
            assign w_en[g] = w_co[g-1];
        end
        bcd_digit_cnt #(.MODULUS((g == 1) ? 6 : 10)) u_dig (
            .i_clk    (clk_in),
            .i_ld     (w_ld),
            .i_ld_val (w_ld_val[4*g +: 4]),
            .i_en     (w_en[g]),
            .i_up     (!bus.REVERSE),
            .o_q      (w_cnt[4*g +: 4]),
            .o_nxt    (w_cnt_nxt[4*g +: 4]),
            .o_co     (w_co[g])
        );
    end
    assign w_unused_co = w_co[ND-1];

    always_ff @(posedge clk_in) begin
        if (RESET) begin
            r_pre        <= '0;
            r_speed      <= X1;
            r_hold_d     <= 1'b0;
            r_held       <= w_rst_val;
            bus.Q        <= w_rst_val;
            bus.RUNNING  <= 1'b0;
            bus.DONE     <= 1'b0;
            bus.LOAD_ERR <= 1'b0;
        end else begin
            if (bus.LOAD && w_load_ok) r_pre <= '0;
            else if (w_running)        r_pre <= w_tick ? (w_pre_sum - PW'(TICK_DIV)) : w_pre_sum;
            if (bus.SPEED_UP && !bus.SPEED_DOWN && r_speed != X8)
                r_speed <= speed_t'(r_speed + 2'd1);
            else if (bus.SPEED_DOWN && !bus.SPEED_UP && r_speed != X1)
                r_speed <= speed_t'(r_speed - 2'd1);
            r_hold_d <= bus.HOLD;
            if (w_hold_rise) r_held <= w_cnt;
            bus.Q        <= bus.HOLD ? (w_hold_rise ? w_cnt : r_held) : w_cnt_nxt;
            bus.RUNNING  <= bus.START && (w_cnt_nxt != w_lim_act);
            bus.DONE     <= w_adv && (w_cnt_nxt == w_lim_act);
            bus.LOAD_ERR <= bus.LOAD && !w_load_ok;
        end
    end
endmodule
